amplitude_ratio_divider: RTL

- Downstream of the filter/peak/average stage.
- Takes the averaged peak amplitude before filtering and the averaged peak amplitude after filtering, and pairs one of each.
- Computes the filter's amplitude ratio out/in as an unsigned fixed-point quotient with a sequential restoring divider.
- The ratio feeds the vibration-detect threshold scaling logic.

---
 rtl/amplitude_ratio_divider.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/amplitude_ratio_divider.sv
// amplitude_ratio_divider
// Pairs an averaged pre-filter peak amplitude with an averaged post-filter
// peak amplitude and computes ratio = (out << FRAC_BITS) / in using an
// MSB-first sequential restoring divider (one quotient bit per clock).
// Build option: define RATIO_ROUND_EN to round the quotient half up instead
// of truncating it.
module amplitude_ratio_divider #(
  parameter int DATAWIDTH = 16,
  parameter int FRAC_BITS = 8,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAWIDTH-1:0] AData_in,
  input  logic                 AData_in_en,
  input  logic [DATAWIDTH-1:0] AData_out,
  input  logic                 AData_out_en,
  output logic [OUT_WIDTH-1:0] ratio,
  output logic                 ratio_en,
  output logic                 div_zero,
  output logic                 sat,
  output logic                 busy
);

  // Dividend width: post-filter amplitude with FRAC_BITS zeros appended.
  localparam int N     = DATAWIDTH + FRAC_BITS;
  // One extra bit so a rounding carry out of the top is never lost.
  localparam int QW    = N + 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state_q,    state_d;

  // Capture side: newest strobed value per input plus a "waiting" flag.
  logic [DATAWIDTH-1:0]   hold_in_q,  hold_in_d;
  logic [DATAWIDTH-1:0]   hold_out_q, hold_out_d;
  logic                   pend_in_q,  pend_in_d;
  logic                   pend_out_q, pend_out_d;

  // Divider working operands.
  logic [DATAWIDTH-1:0]   divisor_q,  divisor_d;
  logic [N-1:0]           dividend_q, dividend_d;
  logic [DATAWIDTH-1:0]   rem_q,      rem_d;
  logic [N-1:0]           quot_q,     quot_d;
  logic [CNT_W-1:0]       cnt_q,      cnt_d;

  // Registered outputs.
  logic [OUT_WIDTH-1:0]   ratio_q,    ratio_d;
  logic                   ratio_en_q, ratio_en_d;
  logic                   div_zero_q, div_zero_d;
  logic                   sat_q,      sat_d;
  logic                   busy_q,     busy_d;

  // Datapath helpers.
  logic [DATAWIDTH:0]     rem_shift;
  logic                   rem_ge;
  logic [DATAWIDTH-1:0]   rem_sub;
  logic                   round_up;
  logic [QW-1:0]          q_final;
  logic                   q_over;

  // One restoring step plus the final rounding / overflow evaluation.
  always_comb begin
    // Partial remainder is always below the divisor, so DATAWIDTH+1 bits
    // hold the shifted value and the difference fits back in DATAWIDTH.
    rem_shift = {rem_q, dividend_q[N-1]};
    rem_ge    = (rem_shift >= {1'b0, divisor_q});
    rem_sub   = rem_shift[DATAWIDTH-1:0] - divisor_q;
`ifdef RATIO_ROUND_EN
    // Round half up: remainder/divisor >= 1/2  <=>  2*remainder >= divisor.
    round_up  = (divisor_q != '0) && ({rem_q, 1'b0} >= {1'b0, divisor_q});
`else
    round_up  = 1'b0;
`endif
    q_final   = {1'b0, quot_q} + QW'(round_up);
    // Any bit above the output width means the ratio does not fit.
    q_over    = ((q_final >> OUT_WIDTH) != '0);
  end

  // Next-state logic: input capture, pairing FSM and divide iterations.
  always_comb begin
    state_d    = state_q;
    hold_in_d  = hold_in_q;
    hold_out_d = hold_out_q;
    pend_in_d  = pend_in_q;
    pend_out_d = pend_out_q;
    divisor_d  = divisor_q;
    dividend_d = dividend_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    cnt_d      = cnt_q;
    ratio_d    = ratio_q;
    ratio_en_d = 1'b0;
    div_zero_d = div_zero_q;
    sat_d      = sat_q;

    // Capture is independent of the FSM; a repeat strobe overwrites.
    if (AData_in_en) begin
      hold_in_d = AData_in;
      pend_in_d = 1'b1;
    end
    if (AData_out_en) begin
      hold_out_d = AData_out;
      pend_out_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // Looking at the updated flags lets a completing strobe start the
        // pair on the very edge that samples it, keeping latency fixed.
        if (pend_in_d && pend_out_d) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        divisor_d  = hold_in_q;
        dividend_d = {hold_out_q, {FRAC_BITS{1'b0}}};
        rem_d      = '0;
        quot_d     = '0;
        cnt_d      = '0;
        // The pair is consumed; a strobe arriving now starts the next pair.
        pend_in_d  = AData_in_en;
        pend_out_d = AData_out_en;
        state_d    = S_DIV;
      end

      S_DIV: begin
        dividend_d = {dividend_q[N-2:0], 1'b0};
        if (rem_ge) begin
          rem_d  = rem_sub;
          quot_d = {quot_q[N-2:0], 1'b1};
        end else begin
          rem_d  = rem_shift[DATAWIDTH-1:0];
          quot_d = {quot_q[N-2:0], 1'b0};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        ratio_en_d = 1'b1;
        if (divisor_q == '0) begin
          // Divide by zero runs the full sequence; report it, not overflow.
          ratio_d    = '1;
          div_zero_d = 1'b1;
          sat_d      = 1'b0;
        end else if (q_over) begin
          ratio_d    = '1;
          div_zero_d = 1'b0;
          sat_d      = 1'b1;
        end else begin
          ratio_d    = q_final[OUT_WIDTH-1:0];
          div_zero_d = 1'b0;
          sat_d      = 1'b0;
        end
        if (pend_in_d && pend_out_d) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any divide in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      hold_in_q  <= '0;
      hold_out_q <= '0;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
      divisor_q  <= '0;
      dividend_q <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      cnt_q      <= '0;
      ratio_q    <= '0;
      ratio_en_q <= 1'b0;
      div_zero_q <= 1'b0;
      sat_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_in_q  <= hold_in_d;
      hold_out_q <= hold_out_d;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      divisor_q  <= divisor_d;
      dividend_q <= dividend_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      cnt_q      <= cnt_d;
      ratio_q    <= ratio_d;
      ratio_en_q <= ratio_en_d;
      div_zero_q <= div_zero_d;
      sat_q      <= sat_d;
      busy_q     <= busy_d;
    end
  end

  assign ratio    = ratio_q;
  assign ratio_en = ratio_en_q;
  assign div_zero = div_zero_q;
  assign sat      = sat_q;
  assign busy     = busy_q;

endmodule
